// File: rtl/pixel_source_arbiter.sv
// Two-source pixel bus arbiter: forwards stream A or B, switching only at start-of-frame.
// Also counts forwarded frames and flags a stalled active source.
module pixel_source_arbiter #(
  parameter int unsigned PIXEL_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TO_W           = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel_req,
  input  logic [PIXEL_W-1:0] a_pixel,
  input  logic               a_valid,
  input  logic [15:0]        a_row,
  input  logic [15:0]        a_col,
  input  logic [PIXEL_W-1:0] b_pixel,
  input  logic               b_valid,
  input  logic [15:0]        b_row,
  input  logic [15:0]        b_col,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_valid,
  output logic [15:0]        out_row,
  output logic [15:0]        out_col,
  output logic               active_src,
  output logic               switch_pending,
  output logic [15:0]        frame_count,
  output logic               stall
);

  localparam int unsigned COORD_W = 16;
  localparam int unsigned FC_W    = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [PIXEL_W-1:0] pixel;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } beat_t;

  state_t           state_q, state_d;
  beat_t            out_q, out_d;
  logic             active_q, active_d;
  logic             pend_q, pend_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             stall_q, stall_d;
  logic [TO_W-1:0]  to_q, to_d;

  beat_t beat_a, beat_b, cur_beat, oth_beat, req_beat;
  logic  sof_a, sof_b, cur_sof, oth_sof, req_sof;
  logic  mismatch, to_hit;

  assign beat_a = '{valid: a_valid, pixel: a_pixel, row: a_row, col: a_col};
  assign beat_b = '{valid: b_valid, pixel: b_pixel, row: b_row, col: b_col};

  // SOF is a valid beat at coordinate (0,0)
  assign sof_a = a_valid && (a_row == '0) && (a_col == '0);
  assign sof_b = b_valid && (b_row == '0) && (b_col == '0);

  assign cur_beat = active_q ? beat_b : beat_a;
  assign oth_beat = active_q ? beat_a : beat_b;
  assign cur_sof  = active_q ? sof_b  : sof_a;
  assign oth_sof  = active_q ? sof_a  : sof_b;
  assign req_beat = sel_req  ? beat_b : beat_a;
  assign req_sof  = sel_req  ? sof_b  : sof_a;

  assign mismatch = (sel_req != active_q);
  assign to_hit   = !cur_beat.valid && (to_q == TO_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    active_d = active_q;
    pend_d   = 1'b0;
    fcnt_d   = fcnt_q;
    stall_d  = stall_q;
    to_d     = to_q;

    case (state_q)
      WAIT_SOF: begin
        out_d.valid = 1'b0;
        active_d    = sel_req;
        to_d        = '0;
        if (req_sof) begin
          out_d   = req_beat;
          fcnt_d  = fcnt_q + FC_W'(1);
          stall_d = 1'b0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (to_hit) begin
          // Stall wins over any switch request in the same cycle
          stall_d     = 1'b1;
          out_d.valid = 1'b0;
          active_d    = sel_req;
          to_d        = '0;
          state_d     = WAIT_SOF;
        end else if (mismatch && oth_sof) begin
          out_d    = oth_beat;
          active_d = ~active_q;
          fcnt_d   = fcnt_q + FC_W'(1);
          stall_d  = 1'b0;
          to_d     = '0;
        end else begin
          out_d  = cur_beat;
          pend_d = mismatch;
          if (cur_sof) begin
            fcnt_d  = fcnt_q + FC_W'(1);
            stall_d = 1'b0;
          end
          to_d = cur_beat.valid ? '0 : to_q + TO_W'(1);
        end
      end

      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_SOF;
      out_q    <= '0;
      active_q <= sel_req;
      pend_q   <= 1'b0;
      fcnt_q   <= '0;
      stall_q  <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      fcnt_q   <= fcnt_d;
      stall_q  <= stall_d;
      to_q     <= to_d;
    end
  end

  assign out_pixel      = out_q.pixel;
  assign out_valid      = out_q.valid;
  assign out_row        = out_q.row;
  assign out_col        = out_q.col;
  assign active_src     = active_q;
  assign switch_pending = pend_q;
  assign frame_count    = fcnt_q;
  assign stall          = stall_q;

endmodule

// File: tb/tb_pixel_source_arbiter.sv
// Directed bench for pixel_source_arbiter: forwarding, SOF switching, timeout, wrap and reset.
module tb_pixel_source_arbiter;

  localparam int unsigned PIXEL_W        = 8;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned TO_W           = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               sel_req;
  logic [PIXEL_W-1:0] a_pixel, b_pixel;
  logic               a_valid, b_valid;
  logic [15:0]        a_row, a_col, b_row, b_col;
  logic [PIXEL_W-1:0] out_pixel;
  logic               out_valid;
  logic [15:0]        out_row, out_col;
  logic               active_src, switch_pending, stall;
  logic [15:0]        frame_count;

  int checks = 0;
  int errors = 0;

  pixel_source_arbiter #(
    .PIXEL_W(PIXEL_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel_req(sel_req),
    .a_pixel(a_pixel),
    .a_valid(a_valid),
    .a_row(a_row),
    .a_col(a_col),
    .b_pixel(b_pixel),
    .b_valid(b_valid),
    .b_row(b_row),
    .b_col(b_col),
    .out_pixel(out_pixel),
    .out_valid(out_valid),
    .out_row(out_row),
    .out_col(out_col),
    .active_src(active_src),
    .switch_pending(switch_pending),
    .frame_count(frame_count),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] p, input logic [15:0] r, input logic [15:0] c);
    a_valid = v; a_pixel = p; a_row = r; a_col = c;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] p, input logic [15:0] r, input logic [15:0] c);
    b_valid = v; b_pixel = p; b_row = r; b_col = c;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [7:0] p,
                            input logic [15:0] r, input logic [15:0] c);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".pixel"}, 32'(out_pixel), 32'(p));
    check({tag, ".row"},   32'(out_row),   32'(r));
    check({tag, ".col"},   32'(out_col),   32'(c));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; sel_req = 1'b1;
    drive_a(1'b0, 8'h00, 16'd0, 16'd0);
    drive_b(1'b0, 8'h00, 16'd0, 16'd0);

    // Reset: active_src follows sel_req sampled during reset
    step();
    check("rst_active_b", 32'(active_src), 32'd1);
    sel_req = 1'b0;
    step();
    check("rst_active_a", 32'(active_src), 32'd0);
    check_beat("rst_out", 1'b0, 8'h00, 16'd0, 16'd0);
    check("rst_pend",  32'(switch_pending), 32'd0);
    check("rst_fc",    32'(frame_count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // 1: 4x2 frame from A forwarded with one cycle latency
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive_a(1'b1, 8'(16 + 4 * r + c), 16'(r), 16'(c));
        step();
        check_beat("t1_beat", 1'b1, 8'(16 + 4 * r + c), 16'(r), 16'(c));
      end
    end
    check("t1_fc",     32'(frame_count), 32'd1);
    check("t1_active", 32'(active_src), 32'd0);
    check("t1_pend",   32'(switch_pending), 32'd0);

    // 2: request B mid-frame at A(1,2); B SOF five cycles later
    for (int k = 0; k < 14; k++) begin
      sel_req = (k >= 6);
      drive_a(1'b1, 8'(32 + k), 16'(k / 4), 16'(k % 4));
      if (k >= 11) drive_b(1'b1, 8'(8'hB0 + k - 11), 16'd0, 16'(k - 11));
      else         drive_b(1'b0, 8'h00, 16'd0, 16'd0);
      step();
      if (k < 11) begin
        check_beat("t2_a_beat", 1'b1, 8'(32 + k), 16'(k / 4), 16'(k % 4));
        check("t2_pend", 32'(switch_pending), 32'(k >= 6));
        if (k == 0) check("t2_fc_a", 32'(frame_count), 32'd2);
      end else begin
        check_beat("t2_b_beat", 1'b1, 8'(8'hB0 + k - 11), 16'd0, 16'(k - 11));
        check("t2_active", 32'(active_src), 32'd1);
        check("t2_pend_clr", 32'(switch_pending), 32'd0);
        check("t2_fc_b", 32'(frame_count), 32'd3);
      end
    end

    // 3: sel_req pulses away and back; A SOF while sel_req == active is ignored
    drive_a(1'b0, 8'h00, 16'd0, 16'd0);
    sel_req = 1'b0; drive_b(1'b1, 8'hB3, 16'd0, 16'd3);
    step();
    check("t3_pend1", 32'(switch_pending), 32'd1);
    check_beat("t3_b3", 1'b1, 8'hB3, 16'd0, 16'd3);
    sel_req = 1'b0; drive_b(1'b1, 8'hB4, 16'd1, 16'd0);
    step();
    check("t3_pend2", 32'(switch_pending), 32'd1);
    sel_req = 1'b1; drive_b(1'b1, 8'hB5, 16'd1, 16'd1); drive_a(1'b1, 8'h40, 16'd0, 16'd0);
    step();
    check("t3_pend3", 32'(switch_pending), 32'd0);
    check_beat("t3_b5", 1'b1, 8'hB5, 16'd1, 16'd1);
    check("t3_active", 32'(active_src), 32'd1);
    check("t3_fc", 32'(frame_count), 32'd3);
    drive_a(1'b0, 8'h00, 16'd0, 16'd0); drive_b(1'b1, 8'hB6, 16'd1, 16'd2);
    step();
    check("t3_pend4", 32'(switch_pending), 32'd0);

    // 4: simultaneous SOFs, first with no switch requested, then with one
    sel_req = 1'b1;
    drive_a(1'b1, 8'h55, 16'd0, 16'd0); drive_b(1'b1, 8'hC0, 16'd0, 16'd0);
    step();
    check_beat("t4_stay", 1'b1, 8'hC0, 16'd0, 16'd0);
    check("t4_fc_stay", 32'(frame_count), 32'd4);
    check("t4_act_stay", 32'(active_src), 32'd1);
    sel_req = 1'b0;
    drive_a(1'b1, 8'h56, 16'd0, 16'd0); drive_b(1'b1, 8'hC1, 16'd0, 16'd0);
    step();
    check_beat("t4_switch", 1'b1, 8'h56, 16'd0, 16'd0);
    check("t4_fc_sw", 32'(frame_count), 32'd5);
    check("t4_act_sw", 32'(active_src), 32'd0);
    check("t4_pend", 32'(switch_pending), 32'd0);
    drive_a(1'b1, 8'h57, 16'd0, 16'd1); drive_b(1'b1, 8'hC2, 16'd0, 16'd1);
    step();
    check_beat("t4_after", 1'b1, 8'h57, 16'd0, 16'd1);

    // 5: A goes idle; stall on the 16th idle cycle beats a same-cycle B switch
    drive_b(1'b0, 8'h00, 16'd0, 16'd0);
    for (int i = 1; i <= 15; i++) begin
      drive_a(1'b0, 8'h00, 16'd0, 16'd0);
      step();
      if (i == 1)  check("t5_gap", 32'(out_valid), 32'd0);
      if (i == 15) check("t5_nostall", 32'(stall), 32'd0);
    end
    sel_req = 1'b1; drive_b(1'b1, 8'hD0, 16'd0, 16'd0);
    step();
    check("t5_stall", 32'(stall), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_active", 32'(active_src), 32'd1);
    check("t5_fc", 32'(frame_count), 32'd5);
    sel_req = 1'b0; drive_b(1'b0, 8'h00, 16'd0, 16'd0);
    drive_a(1'b1, 8'h60, 16'd0, 16'd1);
    step();
    check("t5_drop", 32'(out_valid), 32'd0);
    check("t5_stall_held", 32'(stall), 32'd1);
    check("t5_follow", 32'(active_src), 32'd0);
    drive_a(1'b1, 8'h61, 16'd0, 16'd0);
    step();
    check_beat("t5_resume", 1'b1, 8'h61, 16'd0, 16'd0);
    check("t5_stall_clr", 32'(stall), 32'd0);
    check("t5_fc2", 32'(frame_count), 32'd6);

    // 6: back-to-back SOFs up to 0xFFFF, then wrap
    drive_a(1'b1, 8'hEE, 16'd0, 16'd0);
    for (int n = 0; n < 65529; n++) step();
    check("t6_fc_max", 32'(frame_count), 32'h0000FFFF);
    step();
    check("t6_fc_wrap", 32'(frame_count), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd1);
    drive_a(1'b1, 8'h70, 16'd0, 16'd1);
    step();
    drive_a(1'b1, 8'h71, 16'd0, 16'd0);
    step();
    check("t6_fc_one", 32'(frame_count), 32'd1);
    drive_a(1'b1, 8'h72, 16'd0, 16'd1);
    step();

    // Reset mid-frame
    reset = 1'b1; drive_a(1'b1, 8'h73, 16'd0, 16'd2);
    step();
    check_beat("t6_rst", 1'b0, 8'h00, 16'd0, 16'd0);
    check("t6_rst_fc", 32'(frame_count), 32'd0);
    check("t6_rst_stall", 32'(stall), 32'd0);
    check("t6_rst_pend", 32'(switch_pending), 32'd0);
    reset = 1'b0; drive_a(1'b1, 8'h74, 16'd0, 16'd3);
    step();
    check("t6_post_drop", 32'(out_valid), 32'd0);
    drive_a(1'b1, 8'h99, 16'd0, 16'd0);
    step();
    check_beat("t6_post_sof", 1'b1, 8'h99, 16'd0, 16'd0);
    check("t6_post_fc", 32'(frame_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_source_arbiter.md
Name: pixel_source_arbiter

Overview:
Selects one of two pixel streams (A, B) and forwards it to a single downstream pixel bus. Source changes are applied only at a start-of-frame (SOF) so the output never shows a torn frame. The block sits between the camera capture path and the test-pattern generator on one side, and downstream pixel consumers on the other. It also counts forwarded frames and detects a stalled source.

Parameters:
PIXEL_W, 8, pixel word width in bits (FP_M+FP_N+FP_S of the attached pixel bus)
TIMEOUT_CYCLES, 1048576, number of consecutive cycles with no valid from the active source before a stall is declared; must be >=2
TO_W, 21, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
sel_req  in  1  requested source: 0=A, 1=B; level-sensitive, may change at any cycle
a_pixel  in  PIXEL_W  source A pixel
a_valid  in  1  source A valid
a_row  in  16  source A row coordinate
a_col  in  16  source A column coordinate
b_pixel  in  PIXEL_W  source B pixel
b_valid  in  1  source B valid
b_row  in  16  source B row coordinate
b_col  in  16  source B column coordinate
out_pixel  out  PIXEL_W  forwarded pixel
out_valid  out  1  forwarded valid
out_row  out  16  forwarded row
out_col  out  16  forwarded column
active_src  out  1  source currently being forwarded, or the target while in WAIT_SOF
switch_pending  out  1  high while sel_req != active_src and the switch has not yet occurred
frame_count  out  16  count of forwarded SOF beats; wraps 0xFFFF->0
stall  out  1  sticky stall flag; cleared by the next forwarded SOF

Behaviour:
- SOF for a source: valid=1, row=0 and col=0 in the same cycle.
- All outputs are registered. On reset: out_* = 0, active_src = sel_req as sampled during the reset cycle, switch_pending = 0, frame_count = 0, stall = 0, state = WAIT_SOF, timeout counter = 0.
- Reset asserted mid-frame takes priority over all other events. Output drops immediately (next edge) and the block re-enters WAIT_SOF.
- Forwarding latency is exactly 1 cycle: the beat the selected source presents at edge N appears on out_* after edge N.
- State WAIT_SOF:
  - out_valid = 0.
  - active_src follows sel_req every cycle; switch_pending = 0.
  - On SOF from source sel_req: forward that beat, set active_src, frame_count += 1, stall <= 0, go to STREAM.
  - Non-SOF beats from either source are dropped.
- State STREAM:
  - out_* mirror the active source's bus, with 1-cycle latency, including valid=0 gaps.
  - switch_pending = (sel_req != active_src).
  - Every forwarded SOF from the active source increments frame_count and clears stall.
- Switching from STREAM:
  - Occurs when sel_req != active_src and the other source presents SOF in that cycle.
  - In that cycle the new source's SOF is forwarded, active_src toggles, frame_count += 1, switch_pending <= 0.
  - The old source's remaining beats of its partial frame are discarded.
- sel_req toggles back to active_src before the switch: switch_pending clears the next cycle and no switch occurs.
- sel_req toggles several times: only its value in the cycle of the other source's SOF matters.
- Simultaneous SOF on A and B in STREAM:
  - If a switch is pending, take the other source.
  - Otherwise stay on the current source.
  - Exactly one beat is forwarded.
- Timeout:
  - The counter is held at 0 in WAIT_SOF. In STREAM it increments each cycle the active source has valid=0 and clears on valid=1.
  - When the counter reaches TIMEOUT_CYCLES: stall <= 1, out_valid <= 0, go to WAIT_SOF with active_src = sel_req.
  - Timeout takes priority over a switch in the same cycle.
- frame_count wraps modulo 2^16 with no saturation.
- Row/col are passed through unmodified; the block never rewrites coordinates.

Test Plan:
1. Reset with sel_req=0, A sends a 4x2 frame starting (0,0), B idle -> out reproduces A's 8 beats 1 cycle delayed; frame_count=1; active_src=0.
2. In STREAM on A, sel_req->1 while A is at row 1 col 2; B presents SOF 5 cycles later -> switch_pending=1 for those 5 cycles; B's SOF appears on out the next cycle; active_src=1; A beats after that are absent from out; frame_count increments.
3. sel_req pulses 0->1->0 within 3 cycles, with no B SOF in between -> no switch; switch_pending high for at most 3 cycles, then 0.
4. A and B present SOF in the same cycle, with sel_req=1 while active on A -> out_pixel equals B's pixel; exactly one out_valid beat that cycle.
5. TIMEOUT_CYCLES=16; A stops valid in STREAM -> stall=1 and state WAIT_SOF after 16 idle cycles; the next A SOF clears stall and resumes forwarding.
6. Preload via 65535 frames (or force) -> the next SOF wraps frame_count to 0. Asserting reset mid-frame -> out_valid=0 next cycle and frame_count=0.
